led_pattern_gen: RTL
====================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter NUM_LEDS, default 8: LED output width; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter CLK_HZ, default 50000000: input clock frequency in Hz.
REQ-003 Parameter TICK_HZ, default 2: pattern step rate in Hz; CLK_HZ/TICK_HZ SHALL be at least 2.
REQ-004 Parameter PWM_BITS, default 8: breathing PWM resolution; SHALL be at least 2.
REQ-005 Port: clk, input, 1, single system clock; all flops on the rising edge.
REQ-006 Port: rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 Port: ena, input, 1, active-high run enable, synchronous to clk.
REQ-008 Port: mode, input, 3, pattern select; asynchronous (board switches).
REQ-009 Port: led, output, NUM_LEDS, registered LED drive; bit 1 = lit.
REQ-010 Port: tick, output, 1, registered one-cycle step strobe.

Function
REQ-011 Prescaler: counts 0..DIV-1 with DIV = CLK_HZ/TICK_HZ; advances only while ena=1; holds its value while ena=0; tick=1 for exactly the cycle after the prescaler reaches DIV-1; the prescaler wraps to 0 at that point.
REQ-012 mode passes through a two-flop synchroniser; only the synchronised value (msync) is used.
REQ-013 When msync changes, all pattern state SHALL clear on the next clock: counters=0, direction=up, position=0, duty=0; the prescaler is not cleared. A change takes priority over a coincident tick.
REQ-014 Mode 0 (BCD): NUM_LEDS/4 cascaded decade digits, digit 0 in led[3:0]; +1 per tick; a digit at 9 wraps to 0 and carries; all-9s wraps to all-0s.
REQ-015 Mode 1 (binary): NUM_LEDS-bit counter; +1 per tick; wraps from all-1s to 0.
REQ-016 Mode 2 (bounce): NUM_LEDS-bit counter; counts up to all-1s, then down to 0, then up again; endpoints are shown for exactly one tick and never repeated.
REQ-017 Mode 3 (scanner): one-hot at position p; p bounces 0..NUM_LEDS-1..0 with the same endpoint rule as mode 2.
REQ-018 Mode 4 (rotate): one-hot, rotates left by 1 per tick; led[NUM_LEDS-1] rotates to led[0].
REQ-019 Mode 5 (breathe): free-running PWM_BITS counter c, advancing regardless of ena; all LEDs lit when c < duty.
REQ-020 Mode 5 duty control: duty ramps 0 to 2^PWM_BITS-1 and back (bounce rule) by 1 per 2^PWM_BITS PWM periods; the ramp advances only while ena=1.
REQ-021 Modes 6 and 7: led = 0; tick continues to run.
REQ-022 While ena=0: pattern state frozen, led holds its pattern; mode 5 PWM keeps modulating at the frozen duty.
REQ-023 led is a registered function of the current state; led reflects a state update one clock after the update.

Reset
REQ-024 On rst_n=0, immediately: led=0, tick=0, prescaler=0, all pattern state=0, direction=up, synchroniser flops=0 (msync=0).
REQ-025 Reset asserted mid-operation SHALL abort the pattern; after release the block restarts from the REQ-024 state, and the first tick occurs DIV cycles after the first enabled clock.

Structure
REQ-026 Mode encodings (MODE_BCD=0 .. MODE_OFF=6) SHALL be defined once in the shared package led_pkg, together with the digit width constant 4.
REQ-027 The prescaler SHALL be implemented as sub-module led_tick_gen (clk, rst_n, ena -> tick), parametrised by CLK_HZ and TICK_HZ.
REQ-028 The pattern engines share one NUM_LEDS state register plus a direction flop; there SHALL be no per-mode duplicate registers except the PWM counter and duty.

Verification
All scenarios use CLK_HZ=8, TICK_HZ=1 (DIV=8), NUM_LEDS=8, PWM_BITS=2 unless stated.
REQ-029 Mode 1, ena=1, 260 ticks -> led follows 1,2,…,255,0,1,…; tick period exactly 8 clocks.
REQ-030 Mode 0, 100 ticks -> led steps 0x01…0x09, 0x10, …, 0x99, then 0x00.
REQ-031 Mode 3, 16 ticks -> led steps 0x01,0x02,…,0x80,0x40,…,0x01,0x02; no repeated 0x80 or 0x01.
REQ-032 Mode 2 -> ena=0 for 50 clocks mid-count: led and prescaler hold; on resume the next tick arrives after the remaining prescaler count.
REQ-033 Change mode 1 to 4 (counter at 0x37) -> led=0x01 within 4 clocks; a tick coincident with the change is ignored.
REQ-034 Mode 5, then rst_n pulsed low mid-ramp -> led=0 immediately; after release duty restarts at 0; led duty cycle observed as 0/4, 1/4, 2/4, 3/4, 2/4 … over successive ramp steps.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants for the LED pattern generator.
//   MODE_*  : encodings of the 3-bit mode select
//   DIGIT_W : width of one BCD digit
//   dir_e   : count direction for the bouncing engines
package led_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned MODE_W  = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_BCD     = 3'd0,
    MODE_BIN     = 3'd1,
    MODE_BOUNCE  = 3'd2,
    MODE_SCAN    = 3'd3,
    MODE_ROT     = 3'd4,
    MODE_BREATHE = 3'd5,
    MODE_OFF     = 3'd6
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: counts 0..DIV-1 while ena=1 and emits a one-cycle
// registered strobe in the cycle after the count reaches DIV-1.
//   clk, rst_n : clock, async active-low reset
//   ena        : advance enable (count holds while low)
//   tick       : registered step strobe
module led_tick_gen #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic tick
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             at_end_c;

  assign at_end_c = (cnt == CNT_W'(DIV - 1));

  // Prescaler count and strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= ena && at_end_c;
      if (ena) begin
        cnt <= at_end_c ? '0 : cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: BCD / binary / bounce / scanner / rotate / breathe.
//   clk, rst_n : clock, async active-low reset
//   ena        : run enable (freezes pattern state when low)
//   mode       : asynchronous pattern select, synchronised internally
//   led        : registered LED drive, 1 = lit
//   tick       : registered one-cycle step strobe
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned TICK_HZ  = 2,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [MODE_W-1:0]   mode,
  output logic [NUM_LEDS-1:0] led,
  output logic                tick
);

  localparam int unsigned           N_DIG   = NUM_LEDS / DIGIT_W;
  localparam logic [NUM_LEDS-1:0]   CNT_TOP = '1;
  localparam logic [NUM_LEDS-1:0]   POS_TOP = NUM_LEDS'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0]   PWM_TOP = '1;

  logic [MODE_W-1:0]   mode_meta, msync, mode_last;
  logic [NUM_LEDS-1:0] state, state_nxt, led_nxt;
  dir_e                dir, dir_nxt;
  logic [PWM_BITS-1:0] pwm_cnt, pwm_nxt;
  logic [PWM_BITS-1:0] per_cnt, per_nxt;
  logic [PWM_BITS-1:0] duty, duty_nxt;
  logic [NUM_LEDS:0]   bounce_res;
  logic                carry;
  logic                mode_change_c;
  logic                step_c;

  led_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tick  (tick)
  );

  assign mode_change_c = (msync != mode_last);
  assign step_c        = tick & ena;

  // One bounce step: returns {new_dir_is_down, new_value}; endpoints turn
  // around immediately so each end value is shown for one step only.
  function automatic logic [NUM_LEDS:0] bounce_next(
    input logic [NUM_LEDS-1:0] v,
    input dir_e                d,
    input logic [NUM_LEDS-1:0] top
  );
    logic [NUM_LEDS:0] r;
    if (d == DIR_UP) begin
      r = (v == top) ? {1'b1, v - NUM_LEDS'(1)} : {1'b0, v + NUM_LEDS'(1)};
    end else begin
      r = (v == '0) ? {1'b0, v + NUM_LEDS'(1)} : {1'b1, v - NUM_LEDS'(1)};
    end
    return r;
  endfunction

  // Next pattern state and LED drive
  always_comb begin
    state_nxt  = state;
    dir_nxt    = dir;
    pwm_nxt    = pwm_cnt + PWM_BITS'(1);
    per_nxt    = per_cnt;
    duty_nxt   = duty;
    led_nxt    = '0;
    bounce_res = '0;
    carry      = 1'b0;

    if (mode_change_c) begin
      // Mode switch wins over any coincident step
      state_nxt = '0;
      dir_nxt   = DIR_UP;
      pwm_nxt   = '0;
      per_nxt   = '0;
      duty_nxt  = '0;
    end else begin
      if (step_c) begin
        case (msync)
          MODE_BCD: begin
            carry = 1'b1;
            for (int i = 0; i < int'(N_DIG); i++) begin
              if (carry) begin
                if (state[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(9)) begin
                  state_nxt[i*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                  state_nxt[i*DIGIT_W +: DIGIT_W] = state[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
                  carry = 1'b0;
                end
              end
            end
          end
          MODE_BIN: state_nxt = state + NUM_LEDS'(1);
          MODE_BOUNCE: begin
            bounce_res = bounce_next(state, dir, CNT_TOP);
            state_nxt  = bounce_res[NUM_LEDS-1:0];
            dir_nxt    = dir_e'(bounce_res[NUM_LEDS]);
          end
          MODE_SCAN: begin
            bounce_res = bounce_next(state, dir, POS_TOP);
            state_nxt  = bounce_res[NUM_LEDS-1:0];
            dir_nxt    = dir_e'(bounce_res[NUM_LEDS]);
          end
          MODE_ROT: state_nxt = (state == POS_TOP) ? '0 : state + NUM_LEDS'(1);
          default: ;
        endcase
      end

      // Breathe ramp: one duty step per 2^PWM_BITS complete PWM periods
      if ((msync == MODE_BREATHE) && ena && (pwm_cnt == PWM_TOP)) begin
        per_nxt = per_cnt + PWM_BITS'(1);
        if (per_cnt == PWM_TOP) begin
          if (dir == DIR_UP) begin
            if (duty == PWM_TOP) begin
              dir_nxt  = DIR_DOWN;
              duty_nxt = duty - PWM_BITS'(1);
            end else begin
              duty_nxt = duty + PWM_BITS'(1);
            end
          end else begin
            if (duty == '0) begin
              dir_nxt  = DIR_UP;
              duty_nxt = duty + PWM_BITS'(1);
            end else begin
              duty_nxt = duty - PWM_BITS'(1);
            end
          end
        end
      end

      case (msync)
        MODE_BCD, MODE_BIN, MODE_BOUNCE: led_nxt = state;
        MODE_SCAN, MODE_ROT:             led_nxt = NUM_LEDS'(1) << state;
        MODE_BREATHE:                    led_nxt = {NUM_LEDS{pwm_cnt < duty}};
        default:                         led_nxt = '0;
      endcase
    end
  end

  // State register, mode synchroniser and LED register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_meta <= '0;
      msync     <= '0;
      mode_last <= '0;
      state     <= '0;
      dir       <= DIR_UP;
      pwm_cnt   <= '0;
      per_cnt   <= '0;
      duty      <= '0;
      led       <= '0;
    end else begin
      mode_meta <= mode;
      msync     <= mode_meta;
      mode_last <= msync;
      state     <= state_nxt;
      dir       <= dir_nxt;
      pwm_cnt   <= pwm_nxt;
      per_cnt   <= per_nxt;
      duty      <= duty_nxt;
      led       <= led_nxt;
    end
  end

endmodule
